// File: rtl/branch_resolve_ctrl_pkg.sv
// rtl/branch_resolve_ctrl_pkg.sv - branch funct3, FSM and BHT constants plus decode helpers
package branch_resolve_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CMP      = 2'd1;
  localparam logic [1:0] S_RESOLVE  = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [1:0] BHT_INIT = 2'b01;

  // 010/011 are the only reserved branch encodings
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction

  function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] n;
    if (taken) n = (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       n = (ctr == 2'b00) ? ctr : ctr - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// rtl/branch_bht.sv - 2-bit saturating branch history table with async read port
module branch_bht
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] ctr [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= BHT_INIT;
    end else if (upd_en) begin
      ctr[upd_idx] <= ctr_update(ctr[upd_idx], upd_taken);
    end
  end

  // Read sees the array before any same-cycle update lands
  assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - execute-stage conditional branch resolution and redirect FSM
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DATA_BITS    = 64,
  parameter int BHT_IDX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_pc,
  input  logic [DATA_BITS-1:0] in_imm,
  input  logic [DATA_BITS-1:0] in_rs1,
  input  logic [DATA_BITS-1:0] in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic                 in_pred_taken,
  output logic [DATA_BITS-1:0] cmp_a,
  output logic [DATA_BITS-1:0] cmp_b,
  output logic                 cmp_un,
  input  logic                 cmp_eq,
  input  logic                 cmp_lt,
  input  logic                 flush,
  output logic                 redirect_valid,
  input  logic                 redirect_ready,
  output logic [DATA_BITS-1:0] redirect_pc,
  output logic                 done_valid,
  output logic                 illegal,
  input  logic [DATA_BITS-1:0] lookup_pc,
  output logic                 lookup_taken
);

  logic [1:0]           state;
  logic [DATA_BITS-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic [2:0]           funct3_q;
  logic                 pred_q, eq_q, lt_q, taken_q;
  logic [DATA_BITS-1:0] cmp_a_hold, cmp_b_hold;
  logic                 cmp_un_hold;

  logic accept, resolving, legal, taken, correct, bht_we;

  assign in_ready  = (state == S_IDLE) && !rst && !flush;
  assign accept    = in_valid && in_ready;
  assign resolving = (state == S_RESOLVE) && !rst && !flush;
  assign legal     = f3_legal(funct3_q);
  assign taken     = legal && f3_taken(funct3_q, eq_q, lt_q);
  assign correct   = !legal || (taken == pred_q);
  assign bht_we    = resolving && legal;

  assign done_valid = resolving && correct;
  assign illegal    = resolving && !legal;

  // Comparator inputs are live only in CMP and otherwise replay the last operands
  assign cmp_a  = (state == S_CMP) ? rs1_q       : cmp_a_hold;
  assign cmp_b  = (state == S_CMP) ? rs2_q       : cmp_b_hold;
  assign cmp_un = (state == S_CMP) ? funct3_q[1] : cmp_un_hold;

  assign redirect_valid = (state == S_REDIRECT) && !rst;
  assign redirect_pc    = taken_q ? (pc_q + imm_q) : (pc_q + DATA_BITS'(4));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      pred_q      <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      taken_q     <= 1'b0;
      cmp_a_hold  <= '0;
      cmp_b_hold  <= '0;
      cmp_un_hold <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            pc_q     <= in_pc;
            imm_q    <= in_imm;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            funct3_q <= in_funct3;
            pred_q   <= in_pred_taken;
            state    <= S_CMP;
          end
        end
        S_CMP: begin
          cmp_a_hold  <= rs1_q;
          cmp_b_hold  <= rs2_q;
          cmp_un_hold <= funct3_q[1];
          eq_q        <= cmp_eq;
          lt_q        <= cmp_lt;
          state       <= flush ? S_IDLE : S_RESOLVE;
        end
        S_RESOLVE: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            taken_q <= taken;
            state   <= correct ? S_IDLE : S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          // An in-flight redirect is older than any flush source, so flush is ignored here
          if (redirect_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[DATA_BITS-1:BHT_IDX_BITS+2], lookup_pc[1:0]};

  branch_bht #(
    .IDX_BITS (BHT_IDX_BITS)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .upd_en    (bht_we),
    .upd_idx   (pc_q[BHT_IDX_BITS+1:2]),
    .upd_taken (taken),
    .rd_idx    (lookup_pc[BHT_IDX_BITS+1:2]),
    .rd_taken  (lookup_taken)
  );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - scoreboard bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic          in_pred_taken = 1'b0;
  logic [DW-1:0] cmp_a, cmp_b;
  logic          cmp_un, cmp_eq, cmp_lt;
  logic          flush = 1'b0;
  logic          redirect_valid;
  logic          redirect_ready = 1'b0;
  logic [DW-1:0] redirect_pc;
  logic          done_valid, illegal;
  logic [DW-1:0] lookup_pc = '0;
  logic          lookup_taken;

  always #5 clk = ~clk;

  // Behavioural BranchCompare
  assign cmp_eq = (cmp_a == cmp_b);
  assign cmp_lt = cmp_un ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));

  branch_resolve_ctrl #(.DATA_BITS(DW), .BHT_IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_pred_taken(in_pred_taken),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_un(cmp_un), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .done_valid(done_valid), .illegal(illegal),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
  );

  typedef struct {
    logic          is_redirect;
    logic          ill;
    logic [DW-1:0] pc;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] model [16];
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic logic ref_taken(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard: every retirement or accepted redirect consumes one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (done_valid || (redirect_valid && redirect_ready))) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: done=%b redirect=%b pc=%h, required no output", done_valid, redirect_valid, redirect_pc);
      end else begin
        e = sb.pop_front();
        if (done_valid) begin
          if (e.is_redirect || illegal !== e.ill) begin
            n_fail++;
            $display("FAIL sb_done: got done illegal=%b, required redirect=%b illegal=%b", illegal, e.is_redirect, e.ill);
          end
        end else if (!e.is_redirect || redirect_pc !== e.pc) begin
          n_fail++;
          $display("FAIL sb_redirect: got redirect pc=%h, required redirect=%b pc=%h", redirect_pc, e.is_redirect, e.pc);
        end
      end
    end
  end

  task automatic check_bht(input string name);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = {$urandom(), $urandom()};
      lookup_pc[5:2] = i[3:0];
      #1;
      n_checks++;
      if (lookup_taken !== model[i][1]) begin
        n_fail++;
        $display("FAIL %s_bht[%0d]: lookup_taken=%b, required %b", name, i, lookup_taken, model[i][1]);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_during: got %b, required 0", in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 2'b01;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || redirect_valid !== 1'b0 || done_valid !== 1'b0 || illegal !== 1'b0 ||
        cmp_a !== '0 || cmp_b !== '0 || cmp_un !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b rv=%b dv=%b il=%b a=%h b=%h un=%b, required 1 0 0 0 0 0 0",
               in_ready, redirect_valid, done_valid, illegal, cmp_a, cmp_b, cmp_un);
    end
    check_bht("reset");
  endtask

  // Full branch flow with fixed-cycle checks; hold = cycles redirect_ready stays low
  task automatic run_branch(input string name, input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                            input logic [DW-1:0] rs1, input logic [DW-1:0] rs2, input logic [2:0] f3,
                            input logic pred, input int hold, input logic flush_in_redir);
    logic          legal = !(f3 == 3'b010 || f3 == 3'b011);
    logic          tk = legal && ref_taken(f3, rs1, rs2);
    logic          mis = legal && (tk != pred);
    logic [DW-1:0] tgt = tk ? pc + imm : pc + 64'd4;
    logic [3:0]    idx = pc[5:2];
    logic          old_msb = model[idx][1];
    exp_t          e;
    e.is_redirect = mis; e.ill = !legal; e.pc = mis ? tgt : '0;
    sb.push_back(e);
    if (legal) model[idx] = tk ? ((model[idx] == 2'b11) ? 2'b11 : model[idx] + 2'd1)
                               : ((model[idx] == 2'b00) ? 2'b00 : model[idx] - 2'd1);

    @(posedge clk); #1;
    in_valid = 1'b1; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_pred_taken = pred;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_accept: in_ready=%b, required 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_rs1 = {$urandom(), $urandom()}; in_rs2 = ~rs2; in_funct3 = ~f3;
    @(negedge clk);
    n_checks++;
    if (cmp_a !== rs1 || cmp_b !== rs2 || cmp_un !== f3[1] || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_cmp: a=%h b=%h un=%b rdy=%b, required a=%h b=%h un=%b rdy=0",
               name, cmp_a, cmp_b, cmp_un, in_ready, rs1, rs2, f3[1]);
    end
    @(posedge clk); #1 lookup_pc = pc;
    @(negedge clk);
    n_checks++;
    if (done_valid !== !mis || illegal !== !legal || redirect_valid !== 1'b0 || lookup_taken !== old_msb) begin
      n_fail++;
      $display("FAIL %s_resolve: dv=%b il=%b rv=%b lk=%b, required dv=%b il=%b rv=0 lk=%b",
               name, done_valid, illegal, redirect_valid, lookup_taken, !mis, !legal, old_msb);
    end
    if (mis) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1 flush = flush_in_redir;
        @(negedge clk);
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== tgt || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_hold%0d: rv=%b pc=%h rdy=%b, required rv=1 pc=%h rdy=0",
                   name, k, redirect_valid, redirect_pc, in_ready, tgt);
        end
      end
      @(posedge clk); #1 redirect_ready = 1'b1; flush = flush_in_redir;
      @(negedge clk);
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== tgt) begin
        n_fail++;
        $display("FAIL %s_redirect: rv=%b pc=%h, required rv=1 pc=%h", name, redirect_valid, redirect_pc, tgt);
      end
      @(posedge clk); #1 redirect_ready = 1'b0; flush = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || redirect_valid !== 1'b0 || done_valid !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: rdy=%b rv=%b dv=%b il=%b, required 1 0 0 0",
               name, in_ready, redirect_valid, done_valid, illegal);
    end
  endtask

  task automatic test_beq_mispredict();
    run_branch("beq", 64'h1000, 64'h40, 64'h5, 64'h5, 3'b000, 1'b0, 0, 1'b0);
    check_bht("beq");
  endtask

  task automatic test_bltu_blt_saturate();
    test_reset();
    run_branch("bltu", 64'h1000, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b110, 1'b0, 0, 1'b0);
    check_bht("bltu");
    for (int i = 0; i < 4; i++)
      run_branch("blt", 64'h1000, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b100, 1'b1, 0, 1'b0);
    check_bht("blt_sat");
  endtask

  task automatic test_bge_stall();
    run_branch("bge", 64'h2000, 64'h100, 64'h1, 64'h2, 3'b101, 1'b1, 4, 1'b0);
    check_bht("bge");
  endtask

  task automatic test_flush();
    // RESOLVE of a mispredicting BNE
    @(posedge clk); #1;
    in_valid = 1'b1; in_pc = 64'h3004; in_imm = 64'h20; in_rs1 = 64'h7; in_rs2 = 64'h7;
    in_funct3 = 3'b001; in_pred_taken = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done_valid !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_resolve: dv=%b il=%b rdy=%b, required 0 0 0", done_valid, illegal, in_ready);
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_resolve_after: rdy=%b rv=%b, required 1 0", in_ready, redirect_valid);
    end
    // CMP flush
    @(posedge clk); #1 in_valid = 1'b1; in_funct3 = 3'b000; in_rs2 = 64'h8;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || done_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_cmp: rdy=%b dv=%b rv=%b, required 1 0 0", in_ready, done_valid, redirect_valid);
    end
    // IDLE flush suppresses the offer
    @(posedge clk); #1 in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_ready: rdy=%b, required 0", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_idle_noaccept: rdy=%b, required 1", in_ready);
    end
    repeat (3) @(posedge clk);
    check_bht("flush");
  endtask

  task automatic test_illegal();
    run_branch("illegal010", 64'h3008, 64'h10, 64'h3, 64'h3, 3'b010, 1'b1, 0, 1'b0);
    run_branch("illegal011", 64'h300C, 64'h10, 64'h3, 64'h4, 3'b011, 1'b0, 0, 1'b0);
    check_bht("illegal");
  endtask

  task automatic test_wrap();
    run_branch("wrap_nt", 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 64'h1, 64'h2, 3'b000, 1'b1, 1, 1'b0);
    run_branch("wrap_tk", 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h1, 64'h2, 3'b001, 1'b0, 0, 1'b0);
    check_bht("wrap");
  endtask

  task automatic test_back_to_back();
    logic [2:0]    f3s [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
    logic [DW-1:0] a, b, pc, imm;
    for (int i = 0; i < 24; i++) begin
      a   = {$urandom(), $urandom()};
      b   = ($urandom_range(0, 3) == 0) ? a : {$urandom(), $urandom()};
      pc  = {$urandom(), $urandom()} & ~64'h3;
      imm = {{51{$urandom_range(0, 1) == 1}}, 13'($urandom()) & 13'h1FFE};
      run_branch("b2b", pc, imm, a, b, f3s[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    check_bht("b2b");
  endtask

  task automatic test_rst_in_redirect();
    @(posedge clk); #1;
    in_valid = 1'b1; in_pc = 64'h1000; in_imm = 64'h40; in_rs1 = 64'h9; in_rs2 = 64'h9;
    in_funct3 = 3'b000; in_pred_taken = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (redirect_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_redir_pre: rv=%b, required 1", redirect_valid);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 2'b01;
    @(negedge clk);
    n_checks++;
    if (redirect_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_redir_post: rv=%b rdy=%b, required 0 1", redirect_valid, in_ready);
    end
    check_bht("rst_redir");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bltu_blt_saturate();
    test_bge_stall();
    test_flush();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_rst_in_redirect();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences conditional-branch resolution in the RV64 execute stage.
- Accepts one branch at a time from issue and drives the shared BranchCompare datapath (A, B, BrUn); BranchCompare returns BrEq/BrLT.
- Decodes taken/not-taken from funct3, updates a 2-bit saturating branch history table (BHT), and issues a redirect handshake to fetch on mispredict.
- Also serves combinational BHT lookups to fetch.

Parameters:
- DATA_BITS, 64, operand/PC width (matches `DATA_BITS in common.vh).
- BHT_IDX_BITS, 4, log2 of BHT entries (16 entries).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock, synchronous, active-high.
- in_valid  in  1  branch offered by issue.
- in_ready  out  1  high only in IDLE and not in rst.
- in_pc  in  DATA_BITS  branch PC.
- in_imm  in  DATA_BITS  sign-extended B-immediate.
- in_rs1  in  DATA_BITS  rs1 operand value.
- in_rs2  in  DATA_BITS  rs2 operand value.
- in_funct3  in  3  branch funct3.
- in_pred_taken  in  1  prediction fetch used for this branch.
- cmp_a  out  DATA_BITS  to BranchCompare A.
- cmp_b  out  DATA_BITS  to BranchCompare B.
- cmp_un  out  1  to BranchCompare BrUn.
- cmp_eq  in  1  from BranchCompare BrEq.
- cmp_lt  in  1  from BranchCompare BrLT.
- flush  in  1  pipeline kill from a younger/older exception.
- redirect_valid  out  1  mispredict redirect request.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_pc  out  DATA_BITS  corrected next PC.
- done_valid  out  1  one-cycle pulse: branch retired correctly predicted.
- illegal  out  1  one-cycle pulse: funct3 010/011.
- lookup_pc  in  DATA_BITS  fetch PC to predict.
- lookup_taken  out  1  BHT counter MSB for lookup_pc.

Behaviour:
- States: IDLE, CMP, RESOLVE, REDIRECT. The state register is reset to IDLE.
- Reset values: in_ready=0 during rst, then 1. redirect_valid=0, done_valid=0, illegal=0. cmp_a/cmp_b/cmp_un and the captured registers are 0. All BHT counters are 2'b01 (weakly not-taken).
- IDLE:
  - On in_valid && in_ready, capture pc, imm, rs1, rs2, funct3 and pred_taken; go to CMP.
  - Otherwise hold.
- CMP:
  - cmp_a=rs1_q, cmp_b=rs2_q, cmp_un=funct3_q[1].
  - Register cmp_eq/cmp_lt at the end of the cycle; go to RESOLVE.
  - cmp_* outputs hold their last value in all other states.
- RESOLVE: taken is decoded from funct3_q:
  - 000 eq; 001 !eq; 100 lt; 101 !lt; 110 lt; 111 !lt.
  - 010/011: taken=0, illegal pulses, no BHT update, done_valid pulses, go to IDLE.
- RESOLVE, legal funct3:
  - Update BHT[pc_q[BHT_IDX_BITS+1:2]]: increment if taken, decrement if not. Saturate at 3 and 0.
  - If taken==pred_q: pulse done_valid, go to IDLE.
  - Else go to REDIRECT.
- REDIRECT:
  - redirect_valid=1.
  - redirect_pc = taken_q ? pc_q+imm_q : pc_q+4. Addition wraps modulo 2^DATA_BITS.
  - redirect_pc stays stable while valid. Leave to IDLE on redirect_ready.
- Latency: accept in cycle T, then done_valid or first redirect_valid in T+2 (the RESOLVE cycle, with redirect_valid in T+3). Throughput is one branch per 3 cycles minimum.
- flush:
  - In CMP or RESOLVE: go to IDLE next cycle, no BHT update, no done/redirect/illegal pulse. flush has priority over resolution in the same cycle.
  - In IDLE: an accept in the same cycle is suppressed; in_ready is gated by !flush.
  - In REDIRECT: ignored, because the redirect is older than the flush source.
- rst mid-operation: return to IDLE and reinitialise the BHT in the next cycle, whatever the state.
- Lookup:
  - lookup_taken = BHT[lookup_pc[BHT_IDX_BITS+1:2]][1], combinational.
  - On a simultaneous update to the same index, the lookup returns the pre-update value.

Decomposition:
- Shared package/header (common.vh additions): funct3 encodings F3_BEQ..F3_BGEU; state encodings S_IDLE..S_REDIRECT (2 bits); BHT_INIT=2'b01.
- One sub-module: branch_bht, which holds the counter array, reset init, saturating update port and async read port.

Test Plan:
- BEQ, rs1=rs2=0x5, pred=0, pc=0x1000, imm=0x40 -> redirect_valid in T+3, redirect_pc=0x1040, BHT[0] goes 01->10.
- BLTU, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1, pred=0 -> cmp_un=1, not taken, done_valid pulse in T+2, no redirect, BHT[0] goes 01->00.
- BLT same operands, pred=1 -> cmp_un=0, taken (-1<1), done_valid pulse; then 3 more taken BLT at the same pc -> counter saturates at 11, lookup_taken=1.
- Mispredicted not-taken BGE (rs1=1, rs2=2, pred=1, pc=0x2000) with redirect_ready low for 4 cycles -> redirect_valid and redirect_pc=0x2004 held stable for 4 cycles, in_ready=0 throughout, IDLE after ready.
- flush asserted in RESOLVE of a mispredicting BNE -> no redirect, no done_valid, BHT unchanged, in_ready=1 next cycle.
- funct3=010 -> illegal and done_valid pulse in T+2, BHT unchanged. Also, rst asserted during REDIRECT -> redirect_valid=0 and all counters 01 after one cycle.
